// File: rtl/uart_tx_frame_pkg.sv
// Shared UART definitions: FSM state encoding, line levels and parity selectors.
package uart_tx_frame_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } state_t;

  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam logic IDLE_LVL  = 1'b1;

  localparam logic EVEN = 1'b0;
  localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_tx_frame_if.sv
// Parallel request / serial line bundle of the UART transmitter.
interface uart_tx_frame_if #(parameter int Data_Width = 8);
  import uart_tx_frame_pkg::*;

  logic [Data_Width-1:0] P_DATA;
  logic                  Data_Valid;
  logic                  PAR_EN;
  logic                  PAR_TYP;
  logic                  TX_OUT;
  logic                  Busy;

  modport master (output P_DATA, Data_Valid, PAR_EN, PAR_TYP, input TX_OUT, Busy);
  modport slave  (input P_DATA, Data_Valid, PAR_EN, PAR_TYP, output TX_OUT, Busy);

endinterface

// File: rtl/uart_tx_frame_tx_serializer.sv
// Data shift register and bit counter; presents the word LSB first, one bit per shift.
module tx_serializer
  import uart_tx_frame_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [Data_Width-1:0] data_in,
  input  logic                  clear,
  input  logic                  shift,
  output logic                  bit_out,
  output logic                  ser_done
);

  localparam int CW = $clog2(Data_Width);
  localparam logic [CW-1:0] LAST = CW'(Data_Width - 1);

  logic [Data_Width-1:0] shreg;
  logic [CW-1:0]         cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg <= '0;
      cnt   <= '0;
    end else begin
      if (load)       shreg <= data_in;
      else if (shift) shreg <= shreg >> 1;
      // Counter may step past LAST on the final shift; the FSM has already left DATA.
      if (clear)      cnt <= '0;
      else if (shift) cnt <= cnt + 1'b1;
    end
  end

  assign bit_out  = shreg[0];
  assign ser_done = (cnt == LAST);

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, data LSB first, optional parity, stop bit; one bit per CLK.
module uart_tx_frame
  import uart_tx_frame_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input logic            CLK,
  input logic            RST,
  uart_tx_frame_if.slave bus
);

  state_t state, next_state;
  logic   accept;
  logic   tx_next;
  logic   tx_q, busy_q;
  logic   par_en_q, par_q;
  logic   ser_bit, ser_done;

  function automatic logic parity_bit(input logic [Data_Width-1:0] word, input logic typ);
    logic p;
    case (typ)
      EVEN:    p = ^word;
      ODD:     p = ~(^word);
      default: p = ^word;
    endcase
    return p;
  endfunction

  tx_serializer #(.Data_Width(Data_Width)) u_ser (
    .clk      (CLK),
    .rst      (RST),
    .load     (accept),
    .data_in  (bus.P_DATA),
    .clear    (state == START),
    .shift    (state == DATA),
    .bit_out  (ser_bit),
    .ser_done (ser_done)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    tx_next    = IDLE_LVL;
    case (state)
      IDLE: begin
        if (bus.Data_Valid) begin
          accept     = 1'b1;
          next_state = START;
        end
      end
      START: begin
        tx_next    = START_BIT;
        next_state = DATA;
      end
      DATA: begin
        tx_next = ser_bit;
        if (ser_done) next_state = par_en_q ? PARITY : STOP;
      end
      PARITY: begin
        tx_next    = par_q;
        next_state = STOP;
      end
      STOP: begin
        tx_next    = STOP_BIT;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Line and Busy trail the state by one edge so both are glitch-free registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      tx_q     <= IDLE_LVL;
      busy_q   <= 1'b0;
      par_en_q <= 1'b0;
      par_q    <= 1'b0;
    end else begin
      tx_q   <= tx_next;
      busy_q <= (state != IDLE);
      if (accept) begin
        par_en_q <= bus.PAR_EN;
        par_q    <= parity_bit(bus.P_DATA, bus.PAR_TYP);
      end
    end
  end

  assign bus.TX_OUT = tx_q;
  assign bus.Busy   = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: frame formats, back-to-back, mid-frame inputs, resets.
module tb_uart_tx_frame;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  logic cap_tx   [32];
  logic cap_busy [32];

  uart_tx_frame_if #(.Data_Width(8)) bus ();

  uart_tx_frame #(.Data_Width(8)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Present a request so the next rising edge accepts it; returns 1 time unit after that edge.
  task automatic accept_word(input logic [7:0] d, input logic pe, input logic pt);
    bus.P_DATA     = d;
    bus.PAR_EN     = pe;
    bus.PAR_TYP    = pt;
    bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.Data_Valid = 1'b0;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      cap_tx[i]   = bus.TX_OUT;
      cap_busy[i] = bus.Busy;
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.P_DATA = 8'h00; bus.PAR_EN = 1'b0; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b0;
    #1 rst = 1'b1;
    #1;
    tests++;
    if (bus.TX_OUT !== 1'b1) begin fails++; $display("FAIL reset_tx: got %b want 1", bus.TX_OUT); end
    tests++;
    if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.Busy); end
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    capture(3);
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) begin
        fails++; $display("FAIL reset_idle[%0d]: tx=%b busy=%b want tx=1 busy=0", i, cap_tx[i], cap_busy[i]);
      end
    end
  endtask

  task automatic test_even_parity();
    string tx_s = "010100101011";
    string bz_s = "111111111110";
    accept_word(8'hA5, 1'b1, 1'b0);
    tests++;
    if (bus.TX_OUT !== 1'b1 || bus.Busy !== 1'b0) begin
      fails++; $display("FAIL even_accept_edge: tx=%b busy=%b want tx=1 busy=0", bus.TX_OUT, bus.Busy);
    end
    capture(tx_s.len());
    for (int i = 0; i < tx_s.len(); i++) begin
      tests++;
      if (cap_tx[i] !== (tx_s[i] == "1")) begin fails++; $display("FAIL even_tx[%0d]: got %b want %s", i, cap_tx[i], tx_s.substr(i, i)); end
      tests++;
      if (cap_busy[i] !== (bz_s[i] == "1")) begin fails++; $display("FAIL even_busy[%0d]: got %b want %s", i, cap_busy[i], bz_s.substr(i, i)); end
    end
  endtask

  task automatic test_odd_parity();
    string tx_s = "010100101111";
    string bz_s = "111111111110";
    accept_word(8'hA5, 1'b1, 1'b1);
    capture(tx_s.len());
    for (int i = 0; i < tx_s.len(); i++) begin
      tests++;
      if (cap_tx[i] !== (tx_s[i] == "1")) begin fails++; $display("FAIL odd_tx[%0d]: got %b want %s", i, cap_tx[i], tx_s.substr(i, i)); end
      tests++;
      if (cap_busy[i] !== (bz_s[i] == "1")) begin fails++; $display("FAIL odd_busy[%0d]: got %b want %s", i, cap_busy[i], bz_s.substr(i, i)); end
    end
  endtask

  task automatic test_no_parity();
    string tx_s = "00000000011";
    string bz_s = "11111111110";
    accept_word(8'h00, 1'b0, 1'b0);
    capture(tx_s.len());
    for (int i = 0; i < tx_s.len(); i++) begin
      tests++;
      if (cap_tx[i] !== (tx_s[i] == "1")) begin fails++; $display("FAIL nopar_tx[%0d]: got %b want %s", i, cap_tx[i], tx_s.substr(i, i)); end
      tests++;
      if (cap_busy[i] !== (bz_s[i] == "1")) begin fails++; $display("FAIL nopar_busy[%0d]: got %b want %s", i, cap_busy[i], bz_s.substr(i, i)); end
    end
  endtask

  task automatic test_back_to_back();
    string tx1 = "000111100011";
    string tx2 = "011000011011";
    string bz  = "111111111110";
    bus.P_DATA = 8'h3C; bus.PAR_EN = 1'b1; bus.PAR_TYP = 1'b0; bus.Data_Valid = 1'b1;
    @(posedge clk);
    #1;
    bus.P_DATA = 8'hC3;
    capture(12);
    bus.Data_Valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_tx[i] !== (tx1[i] == "1")) begin fails++; $display("FAIL b2b_f1_tx[%0d]: got %b want %s", i, cap_tx[i], tx1.substr(i, i)); end
      tests++;
      if (cap_busy[i] !== (bz[i] == "1")) begin fails++; $display("FAIL b2b_f1_busy[%0d]: got %b want %s", i, cap_busy[i], bz.substr(i, i)); end
    end
    capture(12);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_tx[i] !== (tx2[i] == "1")) begin fails++; $display("FAIL b2b_f2_tx[%0d]: got %b want %s", i, cap_tx[i], tx2.substr(i, i)); end
      tests++;
      if (cap_busy[i] !== (bz[i] == "1")) begin fails++; $display("FAIL b2b_f2_busy[%0d]: got %b want %s", i, cap_busy[i], bz.substr(i, i)); end
    end
  endtask

  task automatic test_midframe_inputs();
    string tx_s = "00110100101111";
    string bz_s = "11111111111000";
    logic  tx, bz;
    accept_word(8'h96, 1'b1, 1'b0);
    for (int i = 0; i < tx_s.len(); i++) begin
      @(posedge clk);
      #1;
      tx = bus.TX_OUT;
      bz = bus.Busy;
      if (i == 2) begin bus.P_DATA = 8'hFF; bus.Data_Valid = 1'b1; bus.PAR_TYP = 1'b1; end
      if (i == 3) bus.Data_Valid = 1'b0;
      if (i == 7) bus.PAR_TYP = 1'b0;
      if (i == 8) bus.PAR_TYP = 1'b1;
      tests++;
      if (tx !== (tx_s[i] == "1")) begin fails++; $display("FAIL mid_tx[%0d]: got %b want %s", i, tx, tx_s.substr(i, i)); end
      tests++;
      if (bz !== (bz_s[i] == "1")) begin fails++; $display("FAIL mid_busy[%0d]: got %b want %s", i, bz, bz_s.substr(i, i)); end
    end
    bus.PAR_TYP = 1'b0;
  endtask

  task automatic test_reset_midframe();
    accept_word(8'h00, 1'b0, 1'b0);
    capture(5);
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (cap_tx[i] !== 1'b0 || cap_busy[i] !== 1'b1) begin
        fails++; $display("FAIL rstmid_pre[%0d]: tx=%b busy=%b want tx=0 busy=1", i, cap_tx[i], cap_busy[i]);
      end
    end
    #2 rst = 1'b1;
    #1;
    tests++;
    if (bus.TX_OUT !== 1'b1) begin fails++; $display("FAIL rstmid_async_tx: got %b want 1", bus.TX_OUT); end
    tests++;
    if (bus.Busy !== 1'b0) begin fails++; $display("FAIL rstmid_async_busy: got %b want 0", bus.Busy); end
    @(posedge clk);
    #1 rst = 1'b0;
    capture(12);
    for (int i = 0; i < 12; i++) begin
      tests++;
      if (cap_tx[i] !== 1'b1 || cap_busy[i] !== 1'b0) begin
        fails++; $display("FAIL rstmid_idle[%0d]: tx=%b busy=%b want tx=1 busy=0", i, cap_tx[i], cap_busy[i]);
      end
    end
  endtask

  task automatic test_after_reset();
    string tx_s = "01000000011";
    string bz_s = "11111111110";
    accept_word(8'h01, 1'b0, 1'b0);
    capture(tx_s.len());
    for (int i = 0; i < tx_s.len(); i++) begin
      tests++;
      if (cap_tx[i] !== (tx_s[i] == "1")) begin fails++; $display("FAIL post_rst_tx[%0d]: got %b want %s", i, cap_tx[i], tx_s.substr(i, i)); end
      tests++;
      if (cap_busy[i] !== (bz_s[i] == "1")) begin fails++; $display("FAIL post_rst_busy[%0d]: got %b want %s", i, cap_busy[i], bz_s.substr(i, i)); end
    end
  endtask

  initial begin
    test_reset();
    test_even_parity();
    test_odd_parity();
    test_no_parity();
    test_back_to_back();
    test_midframe_inputs();
    test_reset_midframe();
    test_after_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
# uart_tx_frame

Transmit half of the UART. It accepts a parallel word through a valid/busy handshake and serializes it onto `TX_OUT` as one frame: a start bit, the data LSB first, an optional parity bit, and a stop bit. Each bit lasts exactly one `CLK` cycle, because `CLK` is the TX baud clock supplied by the clock-divider stage. It is the counterpart of the RX deserializer path, so frame format and bit order match the receiver.

## Interface
- `Data_Width`, default 8: width of the parallel input word (≥2).
- `CLK` input, 1 bit: TX baud clock; all state changes on the rising edge.
- `RST` input, 1 bit: asynchronous, active-high reset.
- `P_DATA` input, `Data_Width` bits: parallel word to send.
- `Data_Valid` input, 1 bit: request to send `P_DATA`; sampled at the rising edge.
- `PAR_EN` input, 1 bit: 1 inserts a parity bit.
- `PAR_TYP` input, 1 bit: 0 selects even parity, 1 selects odd parity.
- `TX_OUT` output, 1 bit: serial line; idles high.
- `Busy` output, 1 bit: high while a frame is in progress.

## Operation
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE → START
  - Condition: `Data_Valid`=1 at an edge while in IDLE.
  - On that edge, latch `P_DATA`, `PAR_EN` and `PAR_TYP` into internal registers.
- Transition rules:
  - START → DATA after 1 cycle.
  - DATA → PARITY after `Data_Width` cycles if latched `PAR_EN`=1; otherwise DATA → STOP.
  - PARITY → STOP after 1 cycle.
  - STOP → IDLE after 1 cycle.
- `Data_Valid` is ignored in every state except IDLE.
  - Inputs changing mid-frame do not affect the current frame.
- `TX_OUT` is registered and mux-selected from state:
  - IDLE: 1.
  - START: 0.
  - DATA: latched bit[n], n = 0 … `Data_Width`-1.
  - PARITY: parity bit.
  - STOP: 1.
- Parity bit: XOR-reduction of the latched word for even parity; its inverse for odd parity.
- Bit counter: width `$clog2(Data_Width)`.
  - Cleared on entry to DATA.
  - Increments once per DATA cycle.
  - DATA exits when the counter equals `Data_Width`-1; no wrap is observable.
- `Busy` is registered: 1 in START/DATA/PARITY/STOP, 0 in IDLE.
- Reset value of every output: `TX_OUT`=1, `Busy`=0. The state register returns to IDLE and the counter and data registers clear.
- Reset asserted mid-frame aborts the frame immediately and asynchronously. The line returns high and no partial frame resumes after reset is released.

## Timing
- Reference edge: the edge k that samples `Data_Valid`=1 in IDLE.
- Output timing relative to edge k:
  - `Busy`=1 and `TX_OUT`=0 (start bit) from edge k+1.
  - Data bit n is driven from edge k+2+n.
  - Parity, if enabled, is driven from edge k+2+`Data_Width`.
  - The stop bit follows at the next edge.
- Frame length: `Data_Width`+2 cycles, or `Data_Width`+3 with parity.
- `Busy` falls at the edge that ends the stop bit, in the same cycle the line shows idle.
- Consecutive frames with `Data_Valid` held high:
  - The earliest next accept is the first edge in IDLE.
  - This gives exactly one idle-high cycle between back-to-back frames.
- Input sampling: `P_DATA`, `PAR_EN` and `PAR_TYP` must be valid only at the accept edge.

## Structure
- Shared UART package holds:
  - FSM state encoding (3-bit localparams).
  - Line constants: START_BIT=0, STOP_BIT=1, IDLE_LVL=1.
  - Parity-type constants: EVEN=0, ODD=1.
- One natural sub-module, `tx_serializer`:
  - Holds the data shift register and the bit counter.
  - Outputs the current bit and a `ser_done` flag.
  - The FSM, parity calculation and output mux stay in `uart_tx_frame`.

## Test plan
- Even parity, 0xA5:
  - Stimulus: `P_DATA`=0xA5, `PAR_EN`=1, `PAR_TYP`=0, one-cycle `Data_Valid`.
  - Required `TX_OUT` sequence: 0,1,0,1,0,0,1,0,1,0,1.
  - Required `Busy`: high for exactly 11 cycles.
- Odd parity, 0xA5:
  - Stimulus: `PAR_TYP`=1, otherwise as above.
  - Required response: parity bit 1; all other bits identical.
- No parity, 0x00:
  - Stimulus: `PAR_EN`=0.
  - Required `TX_OUT` sequence: 0,0,0,0,0,0,0,0,0,1.
  - Required `Busy`: high for 10 cycles.
- Back-to-back:
  - Stimulus: `Data_Valid` held high with 0x3C then 0xC3.
  - Required response: two correct frames separated by exactly one idle-high cycle.
- Mid-frame input changes:
  - Stimulus: pulse `Data_Valid` during DATA with `P_DATA`=0xFF, and toggle `PAR_TYP` during the frame.
  - Required response: current frame unchanged; no extra frame after STOP.
- Reset mid-frame:
  - Stimulus: assert `RST` during data bit 3.
  - Required response: `TX_OUT`=1 and `Busy`=0 without waiting for a clock edge.
  - After release, the line stays idle until the next `Data_Valid`.
